// File: rtl/cv32e40n_mem_master_mux.sv
// Merges the core LSU and accelerator data ports onto one OBI data port.
// A per-transaction owner FIFO steers each in-order response back to the master that issued it.
module cv32e40n_mem_master_mux #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_master_sel_i,

    input  logic        core_data_req_i,
    output logic        core_data_gnt_o,
    output logic        core_data_rvalid_o,
    input  logic        core_data_we_i,
    input  logic [3:0]  core_data_be_i,
    input  logic [31:0] core_data_addr_i,
    input  logic [31:0] core_data_wdata_i,
    output logic [31:0] core_data_rdata_o,

    input  logic        apu_data_req_i,
    output logic        apu_data_gnt_o,
    output logic        apu_data_rvalid_o,
    input  logic        apu_data_we_i,
    input  logic [3:0]  apu_data_be_i,
    input  logic [31:0] apu_data_addr_i,
    input  logic [31:0] apu_data_wdata_i,
    output logic [31:0] apu_data_rdata_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,

    output logic        busy_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_APU  = 1'b1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             lock_q, lock_d;
    logic             owner_q, owner_d;
    logic             err_q, err_d;
    logic             fifo_q [MAX_OUTSTANDING];

    logic owner_sel;
    logic owner_req;
    logic full;
    logic empty;
    logic grant_ok;
    logic push;
    logic pop;
    logic head_owner;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A stalled request keeps its owner until granted, so sel toggles cannot disturb it.
    assign owner_sel = lock_q ? owner_q : mem_master_sel_i;
    assign owner_req = (owner_sel == OWNER_APU) ? apu_data_req_i : core_data_req_i;
    assign full      = (cnt_q == CNT_MAX);
    assign empty     = (cnt_q == '0);

    assign data_req_o   = owner_req & ~full & ~rst_i;
    assign grant_ok     = data_gnt_i & ~full & ~rst_i;
    assign data_we_o    = (owner_sel == OWNER_APU) ? apu_data_we_i    : core_data_we_i;
    assign data_be_o    = (owner_sel == OWNER_APU) ? apu_data_be_i    : core_data_be_i;
    assign data_addr_o  = (owner_sel == OWNER_APU) ? apu_data_addr_i  : core_data_addr_i;
    assign data_wdata_o = (owner_sel == OWNER_APU) ? apu_data_wdata_i : core_data_wdata_i;

    assign core_data_gnt_o = grant_ok & (owner_sel == OWNER_CORE);
    assign apu_data_gnt_o  = grant_ok & (owner_sel == OWNER_APU);

    assign push       = data_req_o & data_gnt_i;
    assign pop        = data_rvalid_i & ~empty & ~rst_i;
    assign head_owner = fifo_q[rptr_q];

    assign core_data_rvalid_o = pop & (head_owner == OWNER_CORE);
    assign apu_data_rvalid_o  = pop & (head_owner == OWNER_APU);
    assign core_data_rdata_o  = data_rdata_i;
    assign apu_data_rdata_o   = data_rdata_i;

    assign busy_o = ~empty & ~rst_i;
    assign err_o  = err_q;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        cnt_d   = cnt_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        lock_d  = data_req_o & ~data_gnt_i;
        owner_d = owner_q;
        err_d   = err_q | (data_rvalid_i & empty);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push) wptr_d = ptr_inc(wptr_q);
        if (pop)  rptr_d = ptr_inc(rptr_q);
        if (lock_d) owner_d = owner_sel;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            lock_q  <= 1'b0;
            owner_q <= OWNER_CORE;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the owner FIFO storage is not reset; cnt and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= owner_sel;
    end

endmodule
